// File: rtl/icache_pkg.sv
// Shared types and constants for the OTTER instruction-cache refill logic.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } refill_state_t;

    localparam int BYTE_OFF_W = 2;

    // Width of the word index inside a line; a single-word line still needs one bit.
    function automatic int off_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/refill_counter.sv
// Wrap-around word index plus beat counter for one line refill.
module refill_counter #(
    parameter int WORDS = 4,
    parameter int OFF_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OFF_W-1:0] start_index,
    input  logic             advance,
    output logic [OFF_W-1:0] index,
    output logic             last
);

    logic [OFF_W-1:0] count;

    // index wraps naturally at OFF_W bits, which is the line length for power-of-two lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index <= '0;
            count <= '0;
        end else if (start) begin
            index <= start_index;
            count <= '0;
        end else if (advance) begin
            index <= index + 1'b1;
            count <= count + 1'b1;
        end
    end

    assign last = (count == OFF_W'(WORDS - 1));

endmodule

// File: rtl/icache_refill_ctrl.sv
// Line-refill controller: fetches one cache line per miss, one word per memory beat.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int  ADDR_WIDTH     = 32,
    parameter int  WORDS_PER_LINE = 4,
    parameter int  CWF            = 0,
    localparam int OFF_W          = off_width(WORDS_PER_LINE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    output logic [OFF_W-1:0]      word_sel,
    output logic                  load,
    output logic                  data_good,
    output logic                  busy
);

    localparam int LINE_LSB = OFF_W + BYTE_OFF_W;

    refill_state_t         state;
    logic [ADDR_WIDTH-1:0] base;
    logic [OFF_W-1:0]      index;
    logic [OFF_W-1:0]      start_index;
    logic                  last;
    logic                  start;
    logic                  unused_byte_bits;

    assign start       = (state == IDLE) && miss;
    assign load        = (state == FILL) && mem_valid;
    assign start_index = (CWF != 0) ? miss_addr[LINE_LSB-1:BYTE_OFF_W] : '0;
    assign word_sel    = index;
    assign mem_addr    = base | {{(ADDR_WIDTH-LINE_LSB){1'b0}}, index, {BYTE_OFF_W{1'b0}}};

    // the byte offset within a word never affects the fetch
    assign unused_byte_bits = ^miss_addr[BYTE_OFF_W-1:0];

    refill_counter #(
        .WORDS (WORDS_PER_LINE),
        .OFF_W (OFF_W)
    ) u_counter (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_index (start_index),
        .advance     (load),
        .index       (index),
        .last        (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            base      <= '0;
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            data_good <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        state   <= FILL;
                        base    <= {miss_addr[ADDR_WIDTH-1:LINE_LSB], {LINE_LSB{1'b0}}};
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                FILL: begin
                    // wait states simply hold everything until the next valid beat
                    if (mem_valid && last) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        data_good <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    data_good <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    mem_req   <= 1'b0;
                    busy      <= 1'b0;
                    data_good <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: sequential, critical-word-first and 8-word-line instances.
module tb_icache_refill_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        miss_v  [3];
    logic [31:0] addr_v  [3];
    logic        valid_v [3];

    logic        req0, req1, req2;
    logic [31:0] maddr0, maddr1, maddr2;
    logic [1:0]  ws0, ws1;
    logic [2:0]  ws2;
    logic        load0, load1, load2;
    logic        dg0, dg1, dg2;
    logic        busy0, busy1, busy2;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [2:0]  ws;
        logic        load;
        logic        dg;
        logic        busy;
    } obs_t;

    always #5 clk = ~clk;

    icache_refill_ctrl #(.ADDR_WIDTH(32), .WORDS_PER_LINE(4), .CWF(0)) dut_seq (
        .clk(clk), .reset(reset), .miss(miss_v[0]), .miss_addr(addr_v[0]),
        .mem_req(req0), .mem_addr(maddr0), .mem_valid(valid_v[0]), .word_sel(ws0),
        .load(load0), .data_good(dg0), .busy(busy0));

    icache_refill_ctrl #(.ADDR_WIDTH(32), .WORDS_PER_LINE(4), .CWF(1)) dut_cwf (
        .clk(clk), .reset(reset), .miss(miss_v[1]), .miss_addr(addr_v[1]),
        .mem_req(req1), .mem_addr(maddr1), .mem_valid(valid_v[1]), .word_sel(ws1),
        .load(load1), .data_good(dg1), .busy(busy1));

    icache_refill_ctrl #(.ADDR_WIDTH(32), .WORDS_PER_LINE(8), .CWF(1)) dut_w8 (
        .clk(clk), .reset(reset), .miss(miss_v[2]), .miss_addr(addr_v[2]),
        .mem_req(req2), .mem_addr(maddr2), .mem_valid(valid_v[2]), .word_sel(ws2),
        .load(load2), .data_good(dg2), .busy(busy2));

    function automatic obs_t obs(input int d);
        obs_t o;
        case (d)
            0:       o = '{req0, maddr0, {1'b0, ws0}, load0, dg0, busy0};
            1:       o = '{req1, maddr1, {1'b0, ws1}, load1, dg1, busy1};
            default: o = '{req2, maddr2, ws2, load2, dg2, busy2};
        endcase
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk_quiet(input int d, input string tag);
        obs_t o;
        o = obs(d);
        chk($sformatf("d%0d_%s_req", d, tag), 32'(o.req), 32'd0);
        chk($sformatf("d%0d_%s_load", d, tag), 32'(o.load), 32'd0);
        chk($sformatf("d%0d_%s_dg", d, tag), 32'(o.dg), 32'd0);
        chk($sformatf("d%0d_%s_busy", d, tag), 32'(o.busy), 32'd0);
    endtask

    // One whole refill on instance d. gap: 0 = valid every cycle, 1 = every 3rd cycle, 2 = random.
    // noisy scrambles miss/miss_addr during the fill; chain keeps miss high through DONE so a
    // new refill of the same line starts; started means the miss cycle was already consumed.
    task automatic do_fill(input int d, input logic [31:0] a, input int gap,
                           input bit noisy, input bit chain, input bit started);
        int w, start, beats, cyc, idx;
        logic [31:0] base;
        bit v;
        obs_t o;
        w     = (d == 2) ? 8 : 4;
        start = (d == 0) ? 0 : int'((a >> 2) % w);
        base  = a & ~32'(w * 4 - 1);
        beats = 0;
        cyc   = 0;
        if (!started) begin
            miss_v[d] = 1'b1; addr_v[d] = a; valid_v[d] = 1'b0;
            #1;
            o = obs(d);
            chk($sformatf("d%0d_idle_busy", d), 32'(o.busy), 32'd0);
            @(posedge clk); #1;
        end
        miss_v[d] = 1'b0;
        while (beats < w && cyc < 100) begin
            case (gap)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 2);
                default: v = 1'($urandom_range(0, 1));
            endcase
            valid_v[d] = v;
            if (noisy) begin
                miss_v[d] = 1'($urandom_range(0, 1));
                addr_v[d] = $urandom;
            end
            #1;
            o   = obs(d);
            idx = (start + beats) % w;
            chk($sformatf("d%0d_fill_req", d), 32'(o.req), 32'd1);
            chk($sformatf("d%0d_fill_busy", d), 32'(o.busy), 32'd1);
            chk($sformatf("d%0d_fill_dg", d), 32'(o.dg), 32'd0);
            chk($sformatf("d%0d_fill_ws", d), 32'(o.ws), 32'(idx));
            chk($sformatf("d%0d_fill_addr", d), o.addr, base + 32'(idx * 4));
            chk($sformatf("d%0d_fill_load", d), 32'(o.load), 32'(v));
            if (v) beats++;
            cyc++;
            @(posedge clk); #1;
        end
        if (beats < w) chk($sformatf("d%0d_fill_timeout_beats", d), 32'(beats), 32'(w));
        valid_v[d] = 1'($urandom_range(0, 1));
        miss_v[d]  = chain;
        addr_v[d]  = a;
        #1;
        o = obs(d);
        chk($sformatf("d%0d_done_dg", d), 32'(o.dg), 32'd1);
        chk($sformatf("d%0d_done_busy", d), 32'(o.busy), 32'd1);
        chk($sformatf("d%0d_done_req", d), 32'(o.req), 32'd0);
        chk($sformatf("d%0d_done_load", d), 32'(o.load), 32'd0);
        chk($sformatf("d%0d_done_ws", d), 32'(o.ws), 32'(start));
        @(posedge clk); #1;
        valid_v[d] = 1'b0;
        #1;
        chk_quiet(d, "after_done");
        if (chain) begin
            @(posedge clk); #1;
        end else begin
            miss_v[d] = 1'b0;
        end
    endtask

    initial begin
        obs_t o;
        for (int d = 0; d < 3; d++) begin
            miss_v[d] = 1'b0; addr_v[d] = '0; valid_v[d] = 1'b0;
        end

        // reset values
        #1;
        for (int d = 0; d < 3; d++) begin
            o = obs(d);
            chk_quiet(d, "reset");
            chk($sformatf("d%0d_reset_addr", d), o.addr, 32'd0);
            chk($sformatf("d%0d_reset_ws", d), 32'(o.ws), 32'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // directed line fills, back-to-back and with wait states
        do_fill(0, 32'h0000_1028, 0, 1'b0, 1'b0, 1'b0);
        do_fill(1, 32'h0000_1028, 0, 1'b0, 1'b0, 1'b0);
        do_fill(0, 32'h0000_1028, 1, 1'b0, 1'b0, 1'b0);
        do_fill(1, 32'h0000_1028, 1, 1'b0, 1'b0, 1'b0);
        do_fill(2, 32'h0000_201C, 0, 1'b0, 1'b0, 1'b0);

        // reset after two beats aborts the fill and never yields data_good
        miss_v[1] = 1'b1; addr_v[1] = 32'h0000_1028; valid_v[1] = 1'b0;
        @(posedge clk); #1;
        miss_v[1] = 1'b0; valid_v[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk_quiet(1, "abort");
        o = obs(1);
        chk("d1_abort_ws", 32'(o.ws), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            valid_v[1] = 1'($urandom_range(0, 1));
            #1;
            chk_quiet(1, "post_abort");
            @(posedge clk); #1;
        end
        valid_v[1] = 1'b0;
        do_fill(1, 32'h0000_1034, 0, 1'b0, 1'b0, 1'b0);

        // spurious mem_valid while idle
        for (int c = 0; c < 6; c++) begin
            for (int d = 0; d < 3; d++) valid_v[d] = 1'($urandom_range(0, 1));
            #1;
            for (int d = 0; d < 3; d++) chk_quiet(d, "spurious");
            @(posedge clk); #1;
        end
        for (int d = 0; d < 3; d++) valid_v[d] = 1'b0;

        // miss toggling during fill, random wait states
        do_fill(0, $urandom, 2, 1'b1, 1'b0, 1'b0);
        do_fill(1, $urandom, 2, 1'b1, 1'b0, 1'b0);
        do_fill(2, $urandom, 2, 1'b1, 1'b0, 1'b0);

        // miss held through DONE restarts one cycle after data_good
        do_fill(1, 32'h0000_4004, 0, 1'b0, 1'b1, 1'b0);
        do_fill(1, 32'h0000_4004, 2, 1'b0, 1'b0, 1'b1);
        do_fill(2, 32'h0000_8018, 1, 1'b0, 1'b1, 1'b0);
        do_fill(2, 32'h0000_8018, 0, 1'b0, 1'b0, 1'b1);

        // randomized fills across all instances
        for (int n = 0; n < 8; n++) begin
            do_fill(int'($urandom_range(0, 2)), $urandom, int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
